// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared state encoding and constants for the data-memory arbiter.
package dm_arbiter_pkg;

    localparam int          DM_ADDR_W    = 12;            // DM word index, byte address bits [13:2]
    localparam int          STARVE_CNT_W = 4;             // starvation counter width (limit 1..15)
    localparam logic [31:0] EXT_PC_TAG   = 32'hFFFF_FFFF; // dm_pc value marking a non-CPU access

    typedef enum logic [1:0] {
        ARB_CPU   = 2'd0,  // CPU has priority
        ARB_EXT   = 2'd1,  // ext owns the DM while the CPU is idle
        ARB_FORCE = 2'd2   // one-cycle forced ext grant, CPU stalled
    } arb_state_e;

endpackage

// File: rtl/dm_arb_starve.sv
// dm_arb_starve: counts consecutive cycles in which ext waits without a grant and
// requests a forced grant once the count reaches STARVE_LIMIT.
// Feature macro: DM_ARB_STARVE_EN. When it is undefined there is no counter and
// force_next is tied low, so the ext requester may starve behind a busy CPU.
module dm_arb_starve
    import dm_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ext_req,
    input  logic ext_gnt,
    output logic force_next
);

`ifdef DM_ARB_STARVE_EN
    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
    logic [STARVE_CNT_W:0]   cnt_inc;
    logic                    denied;

    // Count denied ext cycles; a grant or a dropped request clears, all-ones saturates.
    always_comb begin
        denied     = ext_req && !ext_gnt;
        cnt_inc    = {1'b0, cnt_q} + (STARVE_CNT_W+1)'(1);
        cnt_d      = '0;
        force_next = 1'b0;
        if (denied) begin
            cnt_d      = (&cnt_q) ? cnt_q : cnt_inc[STARVE_CNT_W-1:0];
            force_next = (cnt_inc >= (STARVE_CNT_W+1)'(STARVE_LIMIT));
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, ext_req, ext_gnt, 4'(STARVE_LIMIT)};
    assign force_next    = 1'b0;
`endif

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the MEM stage of the CPU
// and a secondary ext requester (debug/DMA). The CPU wins unless the starvation
// logic forces a one-cycle ext grant, during which the CPU is stalled.
// Feature macro: DM_ARB_STARVE_EN enables the starvation counter and ARB_FORCE.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DM_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [31:0]       cpu_pc,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [3:0]        ext_be,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    output logic [ADDR_W-1:0] dm_a,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_pc,
    output logic              dm_read,
    output logic              dm_write,
    input  logic [31:0]       dm_rd
);

`ifdef DM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    arb_state_e  state_q, state_d;
    logic        cpu_serve, ext_serve, stall, force_next;
    logic        ext_rvalid_q, ext_rvalid_d;
    logic [31:0] ext_rdata_q, ext_rdata_d;

    dm_arb_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .reset      (reset),
        .ext_req    (ext_req),
        .ext_gnt    (ext_serve),
        .force_next (force_next)
    );

    // Ownership decode for this cycle; nothing is served while reset is held.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        cpu_serve = 1'b0;
        ext_serve = 1'b0;
        stall     = 1'b0;
        if (reset) begin
            case (state_q)
                ARB_FORCE: begin
                    ext_serve = ext_req;              // a dropped request is simply not served
                    stall     = STARVE_EN && cpu_req;
                end
                ARB_CPU, ARB_EXT: begin
                    if (cpu_req)      cpu_serve = 1'b1;
                    else if (ext_req) ext_serve = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next state: forced grant wins, an ext grant outside ARB_FORCE parks in ARB_EXT.
    always_comb begin
        state_d = ARB_CPU;
        if (force_next)                             state_d = ARB_FORCE;
        else if (ext_serve && state_q != ARB_FORCE) state_d = ARB_EXT;
    end

    // Ext read data is captured at the grant edge and flagged valid for one cycle.
    always_comb begin
        ext_rvalid_d = ext_serve && !ext_we;
        ext_rdata_d  = ext_rvalid_d ? dm_rd : ext_rdata_q;
    end

    // State and ext read-return registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (!reset) begin
            state_q      <= ARB_CPU;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign cpu_stall  = stall;
    assign cpu_rdata  = cpu_serve ? dm_rd : 32'h0;
    assign ext_gnt    = ext_serve;
    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;
    assign dm_read    = (cpu_serve && !cpu_we) || (ext_serve && !ext_we);
    assign dm_write   = (cpu_serve &&  cpu_we) || (ext_serve &&  ext_we);
    assign dm_a       = ext_serve ? ext_addr   : cpu_addr;
    assign dm_wdata   = ext_serve ? ext_wdata  : cpu_wdata;
    assign dm_be      = ext_serve ? ext_be     : cpu_be;
    assign dm_pc      = ext_serve ? EXT_PC_TAG : cpu_pc;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter with a behavioural DM and a
// scoreboard queue of expected ext read data.
module tb_dm_arbiter;

    localparam int          ADDR_W  = 12;
    localparam int          LIMIT   = 4;
    localparam logic [31:0] EXT_TAG = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [3:0]        cpu_be;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata, cpu_pc;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;
    logic              ext_req, ext_we;
    logic [3:0]        ext_be;
    logic [ADDR_W-1:0] ext_addr;
    logic [31:0]       ext_wdata;
    logic              ext_gnt, ext_rvalid;
    logic [31:0]       ext_rdata;
    logic [ADDR_W-1:0] dm_a;
    logic [31:0]       dm_wdata, dm_pc, dm_rd;
    logic [3:0]        dm_be;
    logic              dm_read, dm_write;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_a;
    logic [31:0]       pre_d;
    logic [31:0]       exp_q [$];
    logic [31:0]       exp_word;
    int                n_checks = 0;
    int                n_errors = 0;

    dm_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_be(ext_be), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .dm_a(dm_a), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_pc(dm_pc),
        .dm_read(dm_read), .dm_write(dm_write), .dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, byte-enabled write at the clock edge.
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (dm_write)
            for (int b = 0; b < 4; b++)
                if (dm_be[b]) mem[dm_a][8*b +: 8] <= dm_wdata[8*b +: 8];
    end
    assign dm_rd = mem[dm_a];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = '0; cpu_wdata = '0; cpu_pc = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_be = 4'h0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        step();
        pre_we = 1'b0;
    endtask

    function automatic logic [31:0] b2b_word(input int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 12'h7F0; cpu_wdata = 32'h0BAD_F00D;
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 12'h7F4;
        @(negedge clk);
        n_checks++; if (ext_gnt !== 1'b0)    begin n_errors++; $display("FAIL rst_gnt: got %b want 0", ext_gnt); end
        n_checks++; if (dm_write !== 1'b0)   begin n_errors++; $display("FAIL rst_write: got %b want 0", dm_write); end
        n_checks++; if (dm_read !== 1'b0)    begin n_errors++; $display("FAIL rst_read: got %b want 0", dm_read); end
        n_checks++; if (cpu_stall !== 1'b0)  begin n_errors++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
        n_checks++; if (ext_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_rvalid: got %b want 0", ext_rvalid); end
        n_checks++; if (ext_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_rdata: got %h want 0", ext_rdata); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_rdata); end
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
    endtask

    task automatic test_ext_read();
        step();
        preload(12'h004, 32'h1234_5678);
        ext_req = 1'b1; ext_we = 1'b0; ext_be = 4'hF; ext_addr = 12'h004;
        exp_q.push_back(32'h1234_5678);
        @(negedge clk);
        n_checks++; if (ext_gnt !== 1'b1)     begin n_errors++; $display("FAIL rd_gnt: got %b want 1", ext_gnt); end
        n_checks++; if (dm_read !== 1'b1)     begin n_errors++; $display("FAIL rd_dm_read: got %b want 1", dm_read); end
        n_checks++; if (dm_a !== 12'h004)     begin n_errors++; $display("FAIL rd_addr: got %h want 004", dm_a); end
        n_checks++; if (dm_pc !== EXT_TAG)    begin n_errors++; $display("FAIL rd_pc: got %h want %h", dm_pc, EXT_TAG); end
        n_checks++; if (cpu_rdata !== 32'h0)  begin n_errors++; $display("FAIL rd_cpu_rdata: got %h want 0", cpu_rdata); end
        n_checks++; if (ext_rvalid !== 1'b0)  begin n_errors++; $display("FAIL rd_early_rvalid: got %b want 0", ext_rvalid); end
        step();
        ext_req = 1'b0;
        @(negedge clk);
        n_checks++; if (ext_rvalid !== 1'b1)  begin n_errors++; $display("FAIL rd_rvalid: got %b want 1", ext_rvalid); end
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL rd_data: scoreboard empty at ext_rvalid"); end
        else begin
            exp_word = exp_q.pop_front();
            if (ext_rdata !== exp_word) begin n_errors++; $display("FAIL rd_data: got %h want %h", ext_rdata, exp_word); end
        end
        step();
        @(negedge clk);
        n_checks++; if (ext_rvalid !== 1'b0)  begin n_errors++; $display("FAIL rd_rvalid_once: got %b want 0", ext_rvalid); end
        idle_inputs();
    endtask

    task automatic test_ext_write();
        step();
        preload(12'h020, 32'h5A5A_5A5A);
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'b0011; ext_addr = 12'h020; ext_wdata = 32'h0000_ABCD;
        @(negedge clk);
        n_checks++; if (ext_gnt !== 1'b1)     begin n_errors++; $display("FAIL wr_gnt: got %b want 1", ext_gnt); end
        n_checks++; if (dm_write !== 1'b1)    begin n_errors++; $display("FAIL wr_dm_write: got %b want 1", dm_write); end
        n_checks++; if (dm_read !== 1'b0)     begin n_errors++; $display("FAIL wr_dm_read: got %b want 0", dm_read); end
        n_checks++; if (dm_be !== 4'b0011)    begin n_errors++; $display("FAIL wr_be: got %b want 0011", dm_be); end
        n_checks++; if (dm_pc !== EXT_TAG)    begin n_errors++; $display("FAIL wr_pc: got %h want %h", dm_pc, EXT_TAG); end
        step();
        ext_req = 1'b0;
        @(negedge clk);
        n_checks++; if (ext_rvalid !== 1'b0)  begin n_errors++; $display("FAIL wr_rvalid: got %b want 0", ext_rvalid); end
        n_checks++; if (mem[12'h020] !== 32'h5A5A_ABCD) begin n_errors++; $display("FAIL wr_mem: got %h want 5a5aabcd", mem[12'h020]); end
        idle_inputs();
    endtask

    task automatic test_cpu_priority();
        step();
        preload(12'h030, 32'h3030_3030);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 12'h010; cpu_wdata = 32'hDEAD_BEEF; cpu_pc = 32'h0000_0400;
        ext_req = 1'b1; ext_we = 1'b0; ext_be = 4'hF; ext_addr = 12'h030;
        @(negedge clk);
        n_checks++; if (dm_write !== 1'b1)    begin n_errors++; $display("FAIL pri_write: got %b want 1", dm_write); end
        n_checks++; if (dm_a !== 12'h010)     begin n_errors++; $display("FAIL pri_addr: got %h want 010", dm_a); end
        n_checks++; if (dm_pc !== 32'h400)    begin n_errors++; $display("FAIL pri_pc: got %h want 00000400", dm_pc); end
        n_checks++; if (ext_gnt !== 1'b0)     begin n_errors++; $display("FAIL pri_gnt: got %b want 0", ext_gnt); end
        n_checks++; if (cpu_stall !== 1'b0)   begin n_errors++; $display("FAIL pri_stall: got %b want 0", cpu_stall); end
        step();
        cpu_we = 1'b0; cpu_pc = 32'h0000_0404;
        @(negedge clk);
        n_checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL pri_readback: got %h want deadbeef", cpu_rdata); end
        n_checks++; if (ext_gnt !== 1'b0)     begin n_errors++; $display("FAIL pri_gnt2: got %b want 0", ext_gnt); end
        step();
        cpu_req = 1'b0;
        exp_q.push_back(32'h3030_3030);
        @(negedge clk);
        n_checks++; if (ext_gnt !== 1'b1)     begin n_errors++; $display("FAIL pri_ext_gnt: got %b want 1", ext_gnt); end
        n_checks++; if (dm_a !== 12'h030)     begin n_errors++; $display("FAIL pri_ext_addr: got %h want 030", dm_a); end
        n_checks++; if (cpu_rdata !== 32'h0)  begin n_errors++; $display("FAIL pri_cpu_rdata: got %h want 0", cpu_rdata); end
        step();
        ext_req = 1'b0;
        @(negedge clk);
        n_checks++; if (ext_rvalid !== 1'b1)  begin n_errors++; $display("FAIL pri_rvalid: got %b want 1", ext_rvalid); end
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL pri_data: scoreboard empty at ext_rvalid"); end
        else begin
            exp_word = exp_q.pop_front();
            if (ext_rdata !== exp_word) begin n_errors++; $display("FAIL pri_data: got %h want %h", ext_rdata, exp_word); end
        end
        idle_inputs();
    endtask

    task automatic test_idle();
        step();
        idle_inputs();
        cpu_addr = 12'h010;
        @(negedge clk);
        n_checks++; if (dm_read !== 1'b0)     begin n_errors++; $display("FAIL idle_read: got %b want 0", dm_read); end
        n_checks++; if (dm_write !== 1'b0)    begin n_errors++; $display("FAIL idle_write: got %b want 0", dm_write); end
        n_checks++; if (cpu_rdata !== 32'h0)  begin n_errors++; $display("FAIL idle_cpu_rdata: got %h want 0", cpu_rdata); end
        n_checks++; if (ext_gnt !== 1'b0)     begin n_errors++; $display("FAIL idle_gnt: got %b want 0", ext_gnt); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        step();
        for (int i = 0; i < 4; i++) preload(12'h100 + 12'(i), b2b_word(i));
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                ext_req = 1'b1; ext_we = 1'b0; ext_be = 4'hF; ext_addr = 12'h100 + 12'(i);
                exp_q.push_back(b2b_word(i));
            end else begin
                ext_req = 1'b0;
            end
            @(negedge clk);
            if (i < 4) begin
                n_checks++; if (ext_gnt !== 1'b1) begin n_errors++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, ext_gnt); end
            end
            if (i > 0) begin
                n_checks++; if (ext_rvalid !== 1'b1) begin n_errors++; $display("FAIL b2b_rvalid[%0d]: got %b want 1", i, ext_rvalid); end
                n_checks++;
                if (exp_q.size() == 0) begin n_errors++; $display("FAIL b2b_data[%0d]: scoreboard empty", i); end
                else begin
                    exp_word = exp_q.pop_front();
                    if (ext_rdata !== exp_word) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, ext_rdata, exp_word); end
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_cancel();
        step();
        preload(12'h050, 32'h1111_1111);
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 12'h050; ext_wdata = 32'h2222_2222;
        #2;
        n_checks++; if (dm_write !== 1'b1)    begin n_errors++; $display("FAIL rc_write_pre: got %b want 1", dm_write); end
        reset = 1'b0;
        #1;
        n_checks++; if (dm_write !== 1'b0)    begin n_errors++; $display("FAIL rc_write: got %b want 0", dm_write); end
        n_checks++; if (ext_gnt !== 1'b0)     begin n_errors++; $display("FAIL rc_gnt: got %b want 0", ext_gnt); end
        step();
        n_checks++; if (mem[12'h050] !== 32'h1111_1111) begin n_errors++; $display("FAIL rc_mem: got %h want 11111111", mem[12'h050]); end
        n_checks++; if (ext_rvalid !== 1'b0)  begin n_errors++; $display("FAIL rc_rvalid: got %b want 0", ext_rvalid); end
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
    endtask

`ifdef DM_ARB_STARVE_EN
    task automatic test_starve();
        step();
        preload(12'h044, 32'h5555_AAAA);
        for (int c = 1; c <= 19; c++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 12'h000;
            ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF;
            ext_addr  = (c <= 15) ? 12'h040 : 12'h044;
            ext_wdata = (c <= 15) ? 32'hC0FF_EE00 : 32'hBAD0_BAD0;
            @(negedge clk);
            n_checks++; if (ext_gnt !== (c % 5 == 0))   begin n_errors++; $display("FAIL st_gnt[%0d]: got %b want %b", c, ext_gnt, (c % 5 == 0)); end
            n_checks++; if (cpu_stall !== (c % 5 == 0)) begin n_errors++; $display("FAIL st_stall[%0d]: got %b want %b", c, cpu_stall, (c % 5 == 0)); end
            step();
        end
        n_checks++; if (mem[12'h040] !== 32'hC0FF_EE00) begin n_errors++; $display("FAIL st_mem: got %h want c0ffee00", mem[12'h040]); end
        #1;
        n_checks++; if (ext_gnt !== 1'b1)     begin n_errors++; $display("FAIL sf_gnt_pre: got %b want 1", ext_gnt); end
        n_checks++; if (cpu_stall !== 1'b1)   begin n_errors++; $display("FAIL sf_stall_pre: got %b want 1", cpu_stall); end
        reset = 1'b0;
        #1;
        n_checks++; if (ext_gnt !== 1'b0)     begin n_errors++; $display("FAIL sf_gnt: got %b want 0", ext_gnt); end
        n_checks++; if (dm_write !== 1'b0)    begin n_errors++; $display("FAIL sf_write: got %b want 0", dm_write); end
        n_checks++; if (cpu_stall !== 1'b0)   begin n_errors++; $display("FAIL sf_stall: got %b want 0", cpu_stall); end
        step();
        n_checks++; if (mem[12'h044] !== 32'h5555_AAAA) begin n_errors++; $display("FAIL sf_mem: got %h want 5555aaaa", mem[12'h044]); end
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
    endtask
`else
    task automatic test_no_starve();
        step();
        for (int c = 1; c <= 100; c++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 12'h000;
            ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 12'h040; ext_wdata = 32'hC0FF_EE00;
            @(negedge clk);
            n_checks++; if (ext_gnt !== 1'b0)   begin n_errors++; $display("FAIL ns_gnt[%0d]: got %b want 0", c, ext_gnt); end
            n_checks++; if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL ns_stall[%0d]: got %b want 0", c, cpu_stall); end
            step();
        end
        idle_inputs();
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_ext_read();
        test_ext_write();
        test_cpu_priority();
        test_idle();
        test_back_to_back();
        test_reset_cancel();
`ifdef DM_ARB_STARVE_EN
        test_starve();
`else
        test_no_starve();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL sb_drain: %0d reads never returned, want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
